// File: rtl/seq_pkg.sv
// seq_pkg: shared frame constants and transmitter state encoding.
package seq_pkg;
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} tx_state_t;
    localparam int SEQ_PATTERN_LEN = 8;
    localparam logic [SEQ_PATTERN_LEN-1:0] SEQ_PATTERN = 8'b0110_1101;
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/sequence_transmitter_piso_shifter.sv
// piso_shifter: parallel-load, MSB-first shift register.
module piso_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         msb
);
    logic [W-1:0] q;
    assign msb = q[W-1];
    always_ff @(posedge clk) begin
        if (!reset)     q <= '0;
        else if (load)  q <= d;
        else if (shift) q <= q << 1;
    end
endmodule

// File: rtl/sequence_transmitter.sv
// sequence_transmitter: sends preamble then MSB-first payload, followed by an idle gap.
// Outputs are registered one cycle ahead, so each edge loads the bit for the coming cycle.
module sequence_transmitter import seq_pkg::*; #(
    parameter int                     PATTERN_LEN = SEQ_PATTERN_LEN,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = PATTERN_LEN'(SEQ_PATTERN),
    parameter int                     DATA_W      = 8,
    parameter int                     GAP_CYCLES  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);
    localparam int CW = $clog2(max3(PATTERN_LEN, DATA_W, GAP_CYCLES) + 1);
    tx_state_t state;
    logic [CW-1:0] cnt, cnt_inc;
    logic [PATTERN_LEN-1:0] pat_nxt;
    logic msb, load, shift, pre_last, pay_last, gap_last;
    assign load     = ready && start;
    assign cnt_inc  = cnt + 1'b1;
    assign pat_nxt  = PATTERN << cnt_inc;
    assign pre_last = cnt == CW'(PATTERN_LEN - 1);
    assign pay_last = cnt == CW'(DATA_W - 1);
    assign gap_last = cnt == CW'(GAP_CYCLES - 1);
    // Shift whenever the register MSB is consumed into out_bit.
    assign shift    = (state == PREAMBLE && pre_last) || (state == PAYLOAD && !pay_last);
    piso_shifter #(.W(DATA_W)) u_shift (
        .clk(clk), .reset(reset), .load(load), .shift(shift), .d(data_in), .msb(msb)
    );
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            ready     <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state     <= PREAMBLE;
                    cnt       <= '0;
                    ready     <= 1'b0;
                    busy      <= 1'b1;
                    out_valid <= 1'b1;
                    out_bit   <= PATTERN[PATTERN_LEN-1];
                end
                PREAMBLE: begin
                    cnt     <= pre_last ? '0 : cnt_inc;
                    out_bit <= pre_last ? msb : pat_nxt[PATTERN_LEN-1];
                    state   <= pre_last ? PAYLOAD : PREAMBLE;
                end
                PAYLOAD: if (pay_last) begin
                    done      <= 1'b1;
                    out_valid <= 1'b0;
                    out_bit   <= 1'b0;
                    cnt       <= '0;
                    state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    ready     <= GAP_CYCLES == 0;
                    busy      <= GAP_CYCLES != 0;
                end else begin
                    cnt     <= cnt_inc;
                    out_bit <= msb;
                end
                GAP: begin
                    cnt   <= gap_last ? '0 : cnt_inc;
                    state <= gap_last ? IDLE : GAP;
                    ready <= gap_last;
                    busy  <= !gap_last;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sequence_transmitter.sv
// tb_sequence_transmitter: directed checks of framing, timing, reset abort and a short-frame variant.
module tb_sequence_transmitter;
    import seq_pkg::*;
    logic clk = 1'b0, reset = 1'b0;
    logic start = 1'b0, start2 = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] data2 = '0;
    logic ready, out_bit, out_valid, busy, done;
    logic ready2, out_bit2, out_valid2, busy2, done2;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    sequence_transmitter dut (
        .clk(clk), .reset(reset), .start(start), .data_in(data_in), .ready(ready),
        .out_bit(out_bit), .out_valid(out_valid), .busy(busy), .done(done)
    );
    sequence_transmitter #(.DATA_W(4), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .data_in(data2), .ready(ready2),
        .out_bit(out_bit2), .out_valid(out_valid2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_bit"}, out_bit, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic run_frame(input logic [7:0] d, input string nm);
        logic [15:0] f;
        logic [7:0] win, cap;
        int det;
        f = {SEQ_PATTERN, d};
        win = '0; cap = '0; det = 0;
        start = 1'b1; data_in = d;
        tick;
        start = 1'b0; data_in = ~d;
        for (int k = 1; k <= 19; k++) begin
            check($sformatf("%s_valid@%0d", nm, k), out_valid, k <= 16);
            check($sformatf("%s_bit@%0d", nm, k), out_bit, k <= 16 ? f[15] : 1'b0);
            check($sformatf("%s_done@%0d", nm, k), done, k == 17);
            check($sformatf("%s_ready@%0d", nm, k), ready, k >= 19);
            check($sformatf("%s_busy@%0d", nm, k), busy, k < 19);
            if (out_valid) begin
                win = {win[6:0], out_bit};
                if (k > 8) cap = {cap[6:0], out_bit};
                if (win == SEQ_PATTERN && det == 0) det = k;
            end
            f = f << 1;
            if (k < 19) tick;
        end
        check({nm, "_detect"}, det, 8);
        check({nm, "_payload"}, cap, d);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        int rises, rise2;
        logic prev;
        logic [7:0] cap1, cap2, cap3;
        // reset held low, then released
        tick;
        check_idle("rst_hold1");
        tick;
        check_idle("rst_hold2");
        check("rst_ready2", ready2, 1);
        check("rst_valid2", out_valid2, 0);
        reset = 1'b1;
        tick;
        check_idle("rst_rel");

        run_frame(8'hA5, "a5");

        // continuous start: 00 then FF, frames 19 cycles apart
        rises = 0; rise2 = 0; prev = 1'b0; cap1 = '0; cap2 = '0;
        start = 1'b1; data_in = 8'h00;
        tick;
        data_in = 8'hFF;
        for (int k = 1; k <= 38; k++) begin
            if (out_valid && !prev) begin
                rises++;
                if (rises == 2) rise2 = k;
            end
            prev = out_valid;
            if (k >= 9 && k <= 16) cap1 = {cap1[6:0], out_bit};
            if (k >= 28 && k <= 35) cap2 = {cap2[6:0], out_bit};
            if (k == 18) check("cont_ready18", ready, 0);
            if (k == 19) check("cont_ready19", ready, 1);
            if (k == 20) start = 1'b0;
            if (k < 38) tick;
        end
        check("cont_rises", rises, 2);
        check("cont_period", rise2, 20);
        check("cont_pay0", cap1, 8'h00);
        check("cont_pay1", cap2, 8'hFF);
        check("cont_end_ready", ready, 1);

        // reset during payload bit 3 aborts the frame
        start = 1'b1; data_in = 8'hC3;
        tick;
        start = 1'b0;
        for (int k = 1; k < 12; k++) tick;
        check("abort_valid_pre", out_valid, 1);
        reset = 1'b0;
        tick;
        check_idle("abort");
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick;
            check($sformatf("abort_nodone@%0d", k), done, 0);
            check($sformatf("abort_novalid@%0d", k), out_valid, 0);
        end
        run_frame(8'h5A, "after_abort");

        // DATA_W=4, GAP_CYCLES=0: done and ready together, immediate restart
        start2 = 1'b1; data2 = 4'h9;
        tick;
        data2 = 4'h6;
        cap3 = '0;
        for (int k = 1; k <= 13; k++) begin
            check($sformatf("g0_valid@%0d", k), out_valid2, k <= 12);
            check($sformatf("g0_done@%0d", k), done2, k == 13);
            check($sformatf("g0_ready@%0d", k), ready2, k == 13);
            if (k >= 9 && k <= 12) cap3 = {cap3[6:0], out_bit2};
            tick;
        end
        check("g0_pay", cap3, 8'h09);
        start2 = 1'b0;
        check("g0_restart_valid", out_valid2, 1);
        check("g0_restart_bit", out_bit2, 0);
        check("g0_restart_ready", ready2, 0);
        check("g0_restart_done", done2, 0);
        cap3 = '0;
        for (int j = 1; j <= 13; j++) begin
            if (j >= 9 && j <= 12) cap3 = {cap3[6:0], out_bit2};
            if (j == 13) check("g0_done2", done2, 1);
            if (j < 13) tick;
        end
        check("g0_pay2", cap3, 8'h06);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sequence_transmitter.md
# sequence_transmitter

Serial frame transmitter that drives the single-bit stream consumed by the `sequence_detector`. On each accepted request it sends a fixed sync pattern (the preamble the detector is built to find), then a parallel payload word, MSB first, one bit per clock. A mandatory idle gap follows each frame. The block sits on the transmit side of the serial link, between a host that supplies payload words and the `in_bit` input of a detector.

## Interface
- `PATTERN_LEN`, default 8: number of preamble bits.
- `PATTERN`, default 8'b0110_1101: preamble, sent MSB first.
- `DATA_W`, default 8: payload width in bits, ≥1.
- `GAP_CYCLES`, default 2: idle cycles after the last payload bit, ≥0.

- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous reset, active-low. Sampled on `clk` posedge; `reset`=0 resets the block.
- `start`  in  1: host request; qualified by `ready`.
- `data_in`  in  DATA_W: payload, captured when `start && ready`.
- `ready`  out  1: block can accept a request.
- `out_bit`  out  1: serial bit to the detector's `in_bit`.
- `out_valid`  out  1: `out_bit` carries a frame bit this cycle.
- `busy`  out  1: frame or gap in progress (equals `!ready`).
- `done`  out  1: one-cycle pulse after the last payload bit.

## Operation
- States: IDLE, PREAMBLE, PAYLOAD, GAP.
- IDLE: `ready`=1. `out_valid`=0. `out_bit`=0.
  - On `start`=1, capture `data_in` into the shift register, load the bit counter with 0, and go to PREAMBLE.
- PREAMBLE: `out_bit` = `PATTERN[PATTERN_LEN-1-cnt]`, `out_valid`=1.
  - After bit index `PATTERN_LEN-1`, clear the counter and go to PAYLOAD.
- PAYLOAD: `out_bit` = shift register MSB, `out_valid`=1. The register shifts left one bit per cycle.
  - After `DATA_W` bits, pulse `done` and go to GAP. If `GAP_CYCLES`=0, go to IDLE instead.
- GAP: `out_valid`=0, `out_bit`=0. Count `GAP_CYCLES` cycles, then go to IDLE.
- `start` while `ready`=0 is ignored. It is not queued, and `data_in` is not sampled.
- `data_in` changes after acceptance have no effect on the frame in flight.
- The bit counter is wide enough for max(`PATTERN_LEN`, `DATA_W`, `GAP_CYCLES`). It never wraps within a state.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Timing
- Reset values: state=IDLE, `ready`=1, `busy`=0, `out_valid`=0, `out_bit`=0, `done`=0. The shift register and counter are 0.
- Reset mid-frame: the frame is aborted at that edge with no `done`. The next cycle shows the reset values.
- Accept edge T (`start && ready`):
  - T+1: first preamble bit valid, `ready`=0.
  - Preamble occupies cycles T+1 … T+PATTERN_LEN.
  - Payload occupies cycles T+PATTERN_LEN+1 … T+PATTERN_LEN+DATA_W.
- `done`=1 for exactly one cycle, at T+PATTERN_LEN+DATA_W+1. This is the first GAP cycle, or the first IDLE cycle when `GAP_CYCLES`=0.
- `ready` returns to 1 at T+PATTERN_LEN+DATA_W+1+GAP_CYCLES.
  - `start` in that same cycle is accepted. Back-to-back frames are separated by exactly `GAP_CYCLES` invalid cycles.
- Frame period with continuous `start`: PATTERN_LEN+DATA_W+GAP_CYCLES+1 cycles. This is 19 at the defaults.

## Structure
- Package `seq_pkg` holds:
  - the state enum (IDLE/PREAMBLE/PAYLOAD/GAP, 2-bit encoding);
  - the default `PATTERN` and `PATTERN_LEN` constants, shared with the detector so both ends agree.
- One sub-module: `piso_shifter`, a parameterised parallel-load, MSB-first shift register with `load` and `shift` enables and the same synchronous active-low `reset`.
- The top level holds the FSM, counter, and output registers.

## Test plan
- Reset held low 2 cycles, then released → `ready`=1, `out_valid`=0, `out_bit`=0, `done`=0. The same values must hold during reset.
- `data_in`=8'hA5, `start` for 1 cycle at edge T → `out_valid`=1 for cycles T+1..T+16. Bits are 0110_1101 then 1010_0101. `done` at T+17 only, `ready`=1 at T+19.
- Loop `out_bit` into a `sequence_detector` instance (its `reset` driven with the matching polarity) → `seq_detected` fires at the end of the preamble. Scoreboard-capture the payload bits, gated by `out_valid`.
- `start` held high continuously with `data_in` 8'h00 then 8'hFF → frames 19 cycles apart, exactly 2 invalid cycles between them. `start` during a frame is not accepted.
- `reset` driven low during payload bit 3 → next cycle all outputs at reset values, no `done`. A fresh `start` then produces a complete frame.
- Parameter override `GAP_CYCLES`=0, `DATA_W`=4 → `done` and `ready` both 1 in the cycle after the last bit. A new frame can start immediately.
